// File: rtl/arm_data_bus_responder.sv
// Data-memory responder for the ARM core's load/store port.
// Serves word RAM plus memory-mapped camera and LED registers with zero wait
// states. Camera pixels queue in a circular FIFO. Firmware drains the FIFO by
// reading CAM_DATA.
module arm_data_bus_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int PIXEL_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    input  logic               write_enable,
    input  logic               read_enable,
    output logic [31:0]        read_data,
    input  logic [PIXEL_W-1:0] cam_pixel,
    input  logic               cam_valid,
    output logic               cam_ready,
    output logic [7:0]         led,
    output logic               decode_error
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Register word addresses (byte address >> 2).
    localparam logic [29:0] CAM_DATA_W   = 30'h0000_0400;
    localparam logic [29:0] CAM_STATUS_W = 30'h0000_0401;
    localparam logic [29:0] CAM_CTRL_W   = 30'h0000_0402;
    localparam logic [29:0] LED_W        = 30'h0000_0403;

    // Storage
    logic [31:0]        ram_mem  [RAM_WORDS];
    logic [PIXEL_W-1:0] fifo_mem [FIFO_DEPTH];

    // Control state
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          capture_en_q, capture_en_d;
    logic [7:0]    led_q, led_d;
    logic          decode_error_q, decode_error_d;

    // Address decode
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          ram_hit, cam_data_hit, cam_status_hit, cam_ctrl_hit, led_hit, unmapped;
    logic          unused_addr_bits;

    assign word_addr        = address[31:2];
    assign ram_idx          = address[AW+1:2];
    assign ram_hit          = (address[31:AW+2] == '0);
    assign cam_data_hit     = (word_addr == CAM_DATA_W);
    assign cam_status_hit   = (word_addr == CAM_STATUS_W);
    assign cam_ctrl_hit     = (word_addr == CAM_CTRL_W);
    assign led_hit          = (word_addr == LED_W);
    assign unmapped         = ~(ram_hit | cam_data_hit | cam_status_hit | cam_ctrl_hit | led_hit);
    // Byte offset within a word has no meaning on this word-only bus.
    assign unused_addr_bits = ^address[1:0];

    // FIFO flags and transfer qualifiers
    logic fifo_empty, fifo_full;
    logic ctrl_wr, flush, push, pop, underflow_set, overflow_set;

    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == CW'(FIFO_DEPTH));
    assign cam_ready     = capture_en_q & ~fifo_full;
    assign ctrl_wr       = write_enable & cam_ctrl_hit;
    // Flush overrides any push or pop in the same cycle.
    assign flush         = ctrl_wr & write_data[1];
    assign push          = cam_valid & cam_ready & ~flush;
    assign pop           = read_enable & cam_data_hit & ~fifo_empty & ~flush;
    assign underflow_set = read_enable & cam_data_hit & fifo_empty;
    assign overflow_set  = cam_valid & capture_en_q & fifo_full;

    // Next-state computation for pointers, count, flags and registers
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;
        capture_en_d   = capture_en_q;
        led_d          = led_q;
        decode_error_d = unmapped & (read_enable | write_enable);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end

        // A set event in the same cycle beats the clear request.
        if (ctrl_wr && write_data[0]) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (overflow_set)  overflow_d  = 1'b1;
        if (underflow_set) underflow_d = 1'b1;

        if (ctrl_wr) capture_en_d = write_data[2];
        if (write_enable && led_hit) led_d = write_data[7:0];
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            capture_en_q   <= 1'b0;
            led_q          <= 8'h00;
            decode_error_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            capture_en_q   <= capture_en_d;
            led_q          <= led_d;
            decode_error_q <= decode_error_d;
        end
    end

    // Data RAM store port; contents survive reset
    always_ff @(posedge clk) begin
        if (write_enable && ram_hit) ram_mem[ram_idx] <= write_data;
    end

    // Pixel FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= cam_pixel;
    end

    // Combinational read mux; reads never change state here
    logic [7:0]  count_ext;
    logic [31:0] status_word;

    assign count_ext   = 8'(count_q);
    assign status_word = {16'h0000, count_ext, 3'b000, capture_en_q,
                          underflow_q, overflow_q, fifo_full, fifo_empty};

    // Select the read word for the current address
    always_comb begin
        read_data = 32'h0000_0000;
        if (ram_hit)
            read_data = ram_mem[ram_idx];
        else if (cam_data_hit)
            read_data = fifo_empty ? 32'h0000_0000
                                   : {{(32-PIXEL_W){1'b0}}, fifo_mem[rd_ptr_q]};
        else if (cam_status_hit)
            read_data = status_word;
        else if (cam_ctrl_hit)
            read_data = {29'b0, capture_en_q, 2'b00};
        else if (led_hit)
            read_data = {24'b0, led_q};
    end

    assign led          = led_q;
    assign decode_error = decode_error_q;

endmodule

// File: tb/tb_arm_data_bus_responder.sv
// Directed self-checking bench for arm_data_bus_responder.
module tb_arm_data_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] read_data;
    logic [7:0]  cam_pixel;
    logic        cam_valid;
    logic        cam_ready;
    logic [7:0]  led;
    logic        decode_error;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] A_DATA = 32'h1000;
    localparam logic [31:0] A_STAT = 32'h1004;
    localparam logic [31:0] A_CTRL = 32'h1008;
    localparam logic [31:0] A_LED  = 32'h100C;

    arm_data_bus_responder #(.RAM_WORDS(64), .FIFO_DEPTH(16), .PIXEL_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .cam_pixel    (cam_pixel),
        .cam_valid    (cam_valid),
        .cam_ready    (cam_ready),
        .led          (led),
        .decode_error (decode_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        address = a; write_data = d; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    // Look at read_data without read side effects.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        address = a; read_enable = 1'b0;
        #1 d = read_data;
    endtask

    // Load with read_enable; value captured before the edge that acts on it.
    task automatic load(input logic [31:0] a, output logic [31:0] d);
        address = a; read_enable = 1'b1;
        #1 d = read_data;
        tick();
        read_enable = 1'b0;
    endtask

    task automatic push_px(input logic [7:0] p);
        cam_pixel = p; cam_valid = 1'b1;
        tick();
        cam_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset = 1'b1; address = A_STAT; write_data = '0; write_enable = 1'b0;
        read_enable = 1'b0; cam_pixel = '0; cam_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", read_data, 32'h0000_0001);
        check("reset_ready", {31'b0, cam_ready}, 32'h0);
        check("reset_led", {24'b0, led}, 32'h0);
        check("reset_decerr", {31'b0, decode_error}, 32'h0);
        reset = 1'b0;
        tick();

        // RAM: byte offset ignored, neighbours untouched, read-before-write
        bus_wr(32'h4, 32'hCAFE_F00D);
        bus_wr(32'h8, 32'hDEAD_BEEF);
        bus_wr(32'hB, 32'h1234_5678);
        peek(32'h8, d); check("ram_word2", d, 32'h1234_5678);
        peek(32'h4, d); check("ram_word1", d, 32'hCAFE_F00D);
        bus_wr(32'h10, 32'h0000_0001);
        address = 32'h10; write_data = 32'h0000_0002; write_enable = 1'b1;
        #1 check("ram_rbw_old", read_data, 32'h0000_0001);
        tick(); write_enable = 1'b0;
        peek(32'h10, d); check("ram_rbw_new", d, 32'h0000_0002);

        // Capture three pixels
        bus_wr(A_CTRL, 32'h4);
        peek(A_CTRL, d); check("ctrl_read", d, 32'h0000_0004);
        check("ready_on", {31'b0, cam_ready}, 32'h1);
        push_px(8'h11); push_px(8'h22); push_px(8'h33);
        peek(A_STAT, d); check("cap_status3", d, 32'h0000_0310);
        peek(A_DATA, d); check("peek_no_pop", d, 32'h11);
        load(A_DATA, d); check("cap_pop0", d, 32'h11);
        load(A_DATA, d); check("cap_pop1", d, 32'h22);
        load(A_DATA, d); check("cap_pop2", d, 32'h33);
        peek(A_STAT, d); check("cap_status0", d, 32'h0000_0011);

        // Overflow then underflow
        for (int i = 0; i < 18; i++) begin
            if (i == 15) check("ready_before_full", {31'b0, cam_ready}, 32'h1);
            if (i == 16) check("ready_at_full", {31'b0, cam_ready}, 32'h0);
            push_px(8'(8'h40 + i));
        end
        peek(A_STAT, d); check("ovf_status", d, 32'h0000_1016);
        for (int i = 0; i < 17; i++) begin
            load(A_DATA, d);
            check($sformatf("drain%0d", i), d, (i < 16) ? 32'h40 + 32'(i) : 32'h0);
        end
        peek(A_STAT, d); check("udf_status", d, 32'h0000_001D);
        bus_wr(A_CTRL, 32'h5);
        peek(A_STAT, d); check("sticky_clear", d, 32'h0000_0011);

        // Simultaneous push and pop with five queued
        for (int i = 0; i < 5; i++) push_px(8'(8'h50 + i));
        address = A_DATA; read_enable = 1'b1; cam_pixel = 8'h55; cam_valid = 1'b1;
        #1 check("both_pop", read_data, 32'h50);
        tick(); read_enable = 1'b0; cam_valid = 1'b0;
        peek(A_STAT, d); check("both_count", d, 32'h0000_0510);
        for (int i = 0; i < 5; i++) begin
            load(A_DATA, d);
            check($sformatf("order%0d", i), d, 32'h51 + 32'(i));
        end
        // Push and pop on an empty FIFO
        address = A_DATA; read_enable = 1'b1; cam_pixel = 8'h66; cam_valid = 1'b1;
        #1 check("empty_both_rd", read_data, 32'h0);
        tick(); read_enable = 1'b0; cam_valid = 1'b0;
        peek(A_STAT, d); check("empty_both_stat", d, 32'h0000_0118);
        load(A_DATA, d); check("empty_both_px", d, 32'h66);
        bus_wr(A_CTRL, 32'h5);

        // Flush beats a same-cycle push
        push_px(8'h71); push_px(8'h72); push_px(8'h73);
        address = A_CTRL; write_data = 32'h6; write_enable = 1'b1;
        cam_pixel = 8'h74; cam_valid = 1'b1;
        tick(); write_enable = 1'b0; cam_valid = 1'b0;
        peek(A_STAT, d); check("flush_status", d, 32'h0000_0011);

        // Unmapped access
        peek(32'h2000, d); check("unmapped_peek", d, 32'h0);
        tick();
        check("peek_no_decerr", {31'b0, decode_error}, 32'h0);
        address = 32'h2000; read_enable = 1'b1;
        #1 check("unmapped_rd", read_data, 32'h0);
        check("decerr_before", {31'b0, decode_error}, 32'h0);
        tick(); read_enable = 1'b0;
        check("decerr_pulse", {31'b0, decode_error}, 32'h1);
        tick();
        check("decerr_gone", {31'b0, decode_error}, 32'h0);

        // LED
        bus_wr(A_LED, 32'hFFFF_FFA5);
        check("led_out", {24'b0, led}, 32'hA5);
        peek(A_LED, d); check("led_read", d, 32'h0000_00A5);

        // Asynchronous reset mid-operation
        bus_wr(A_LED, 32'hFF);
        for (int i = 0; i < 7; i++) push_px(8'(8'h80 + i));
        peek(A_STAT, d); check("pre_reset_stat", d, 32'h0000_0710);
        #2 reset = 1'b1;
        #1;
        check("arst_status", read_data, 32'h0000_0001);
        check("arst_led", {24'b0, led}, 32'h0);
        check("arst_ready", {31'b0, cam_ready}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        peek(32'h8, d); check("ram_keeps", d, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
